// File: rtl/idp_ctrl.sv
// idp_ctrl: fetch/execute controller driving the integer datapath.
// Define IDP_CTRL_INSTRET_EN to build the retired-instruction counter.
module idp_ctrl #(
    parameter int                PC_W   = 8,
    parameter logic [PC_W-1:0]   RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            imem_valid,
    input  logic            N,
    input  logic            Z,
    input  logic            C,
    output logic            sel,
    output logic            en,
    output logic [2:0]      write_add,
    output logic [2:0]      fir_add,
    output logic [2:0]      sec_add,
    output logic [3:0]      opcode,
    output logic [15:0]     secin,
    output logic [2:0]      flags,
    output logic            halted,
    output logic [15:0]     instret
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic [1:0]      cls;
    logic            is_itype;
    logic            br_take;
    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] pc_inc;

    assign cls       = ir[15:14];
    assign is_itype  = (cls == 2'b01);
    assign imem_addr = pc;
    assign pc_inc    = pc + PC_ONE;

    // Datapath control fields decoded straight from the instruction register
    always_comb begin
        write_add = ir[9:7];
        opcode    = ir[13:10];
        sel       = is_itype;
        fir_add   = is_itype ? ir[9:7] : ir[6:4];
        sec_add   = is_itype ? 3'd0 : ir[3:1];
        secin     = is_itype ? {{9{ir[6]}}, ir[6:0]} : 16'd0;
    end

    // Branch offset sign-extended (or truncated) to the PC width
    always_comb begin
        br_off = '0;
        for (int i = 0; i < PC_W; i++) begin
            br_off[i] = ir[(i < 12) ? i : 11];
        end
    end

    // Branch condition evaluated on latched flags {N,Z,C}
    always_comb begin
        br_take = 1'b0;
        case (ir[13:12])
            2'b00:   br_take = 1'b1;
            2'b01:   br_take = flags[1];
            2'b10:   br_take = flags[2];
            default: br_take = flags[0];
        endcase
    end

    // Control FSM with registered handshake, write-enable and halt outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            pc       <= RST_PC;
            ir       <= '0;
            flags    <= '0;
            imem_req <= 1'b0;
            en       <= 1'b0;
            halted   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        ir       <= imem_rdata;
                        state    <= S_EXEC;
                        imem_req <= 1'b0;
                        en       <= ~imem_rdata[15];
                    end
                end
                S_EXEC: begin
                    en <= 1'b0;
                    if (cls == 2'b11 && ir[13]) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        if (!cls[1]) begin
                            flags <= {N, Z, C};
                            pc    <= pc_inc;
                        end else if (cls == 2'b10 && br_take) begin
                            pc <= pc_inc + br_off;
                        end else begin
                            pc <= pc_inc;
                        end
                    end
                end
                S_HALT: begin
                    halted   <= 1'b1;
                    imem_req <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef IDP_CTRL_INSTRET_EN
    // Retired-instruction counter, one count per execute cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            instret <= '0;
        end else if (state == S_EXEC) begin
            instret <= instret + 16'd1;
        end
    end
`else
    assign instret = 16'd0;
`endif

endmodule
